// File: rtl/mux_na1_registrado_if.sv
// Bus bundle for the registered N-to-1 mux: producer side (data, valids, accepts),
// consumer side (registered word, valid, ready) and the selection controls.
interface mux_na1_registrado_if #(
    parameter int ANCHO      = 32,
    parameter int N_ENTRADAS = 4
);
    localparam int SEL_W = $clog2(N_ENTRADAS);

    logic                        Modo;
    logic [SEL_W-1:0]            Control;
    logic [N_ENTRADAS*ANCHO-1:0] Entradas;
    logic [N_ENTRADAS-1:0]       Validos;
    logic [N_ENTRADAS-1:0]       Aceptado;
    logic                        Listo;
    logic [ANCHO-1:0]            Salida;
    logic                        Salida_Valida;
    logic [SEL_W-1:0]            Canal;

    modport master (
        output Modo, Control, Entradas, Validos, Listo,
        input  Aceptado, Salida, Salida_Valida, Canal
    );

    modport slave (
        input  Modo, Control, Entradas, Validos, Listo,
        output Aceptado, Salida, Salida_Valida, Canal
    );
endinterface

// File: rtl/mux_na1_registrado.sv
// Registered N-to-1 multiplexer with valid/ready output and two grant modes:
// fixed select by Control, or round-robin starting after the last granted channel.
module mux_na1_registrado #(
    parameter int ANCHO      = 32,
    parameter int N_ENTRADAS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    mux_na1_registrado_if.slave    bus
);
    localparam int SEL_W = $clog2(N_ENTRADAS);
    localparam int N_EXT = 1 << SEL_W;

    logic [ANCHO-1:0] r_salida;
    logic             r_vld;
    logic [SEL_W-1:0] r_canal;
    logic [SEL_W-1:0] r_ultimo;

    logic [N_EXT-1:0]      w_val_ext;
    logic                  w_hay_grant;
    logic [SEL_W-1:0]      w_grant;
    logic                  w_carga;
    logic [ANCHO-1:0]      w_dato;
    logic [N_ENTRADAS-1:0] w_acept;

    function automatic logic [SEL_W-1:0] rr_idx(input logic [SEL_W-1:0] u, input int k);
        return SEL_W'((int'(u) + k) % N_ENTRADAS);
    endfunction

    // Padding to a power of two makes out-of-range Control values read as "not valid".
    always_comb begin
        w_val_ext = '0;
        for (int i = 0; i < N_ENTRADAS; i++) w_val_ext[i] = bus.Validos[i];
    end

    // Round-robin scans from the far end so the nearest candidate after Ultimo wins.
    always_comb begin
        w_hay_grant = 1'b0;
        w_grant     = '0;
        if (!bus.Modo) begin
            w_hay_grant = w_val_ext[bus.Control];
            w_grant     = bus.Control;
        end else begin
            for (int k = N_ENTRADAS; k >= 1; k--) begin
                if (w_val_ext[rr_idx(r_ultimo, k)]) begin
                    w_hay_grant = 1'b1;
                    w_grant     = rr_idx(r_ultimo, k);
                end
            end
        end
    end

    assign w_carga = (!r_vld || bus.Listo) && w_hay_grant && !reset;

    always_comb begin
        w_dato  = '0;
        w_acept = '0;
        for (int i = 0; i < N_ENTRADAS; i++) begin
            if (SEL_W'(i) == w_grant) begin
                w_dato     = bus.Entradas[i*ANCHO +: ANCHO];
                w_acept[i] = w_carga;
            end
        end
    end

    // Output stage: load overrides drain, so a consumed word is replaced on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_salida <= '0;
            r_vld    <= 1'b0;
            r_canal  <= '0;
            r_ultimo <= SEL_W'(N_ENTRADAS - 1);
        end else if (w_carga) begin
            r_salida <= w_dato;
            r_vld    <= 1'b1;
            r_canal  <= w_grant;
            if (bus.Modo) r_ultimo <= w_grant;
        end else if (r_vld && bus.Listo) begin
            r_vld <= 1'b0;
        end
    end

    assign bus.Aceptado      = w_acept;
    assign bus.Salida        = r_salida;
    assign bus.Salida_Valida = r_vld;
    assign bus.Canal         = r_canal;
endmodule

// File: tb/tb_mux_na1_registrado.sv
// Bench for mux_na1_registrado: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a queue-free behavioural model.
module tb_mux_na1_registrado;
    localparam int ANCHO = 32;
    localparam int N     = 4;
    localparam int SEL_W = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mux_na1_registrado_if #(.ANCHO(ANCHO), .N_ENTRADAS(N)) bus ();
    mux_na1_registrado #(.ANCHO(ANCHO), .N_ENTRADAS(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    bit             m_vld;
    logic [ANCHO-1:0] m_sal;
    int             m_can;
    int             m_ptr;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input bit modo, input int ctrl, input logic [N-1:0] v, input int ptr);
        if (!modo) begin
            if (ctrl < N) begin
                if (v[ctrl]) return ctrl;
            end
            return -1;
        end
        for (int k = 1; k <= N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N*ANCHO-1:0] rnd_data();
        logic [N*ANCHO-1:0] d;
        for (int i = 0; i < N; i++) d[i*ANCHO +: ANCHO] = $urandom;
        return d;
    endfunction

    // One clock of traffic: drive, check accept, advance the model across the edge, check outputs.
    task automatic cycle(input bit modo, input int ctrl, input logic [N-1:0] v, input bit listo,
                         input logic [N*ANCHO-1:0] d);
        int g;
        bit take;
        logic [N-1:0] acc;
        bus.Modo     = modo;
        bus.Control  = SEL_W'(ctrl);
        bus.Validos  = v;
        bus.Listo    = listo;
        bus.Entradas = d;
        #1;
        g    = pick(modo, ctrl, v, m_ptr);
        take = (g >= 0) && (!m_vld || listo);
        acc  = '0;
        if (take) acc[g] = 1'b1;
        chk("aceptado", 64'(bus.Aceptado), 64'(acc));
        @(posedge clk);
        if (take) begin
            m_sal = d[g*ANCHO +: ANCHO];
            m_can = g;
            m_vld = 1'b1;
            if (modo) m_ptr = g;
        end else if (m_vld && listo) begin
            m_vld = 1'b0;
        end
        #1;
        chk("salida_valida", 64'(bus.Salida_Valida), 64'(m_vld));
        chk("salida", 64'(bus.Salida), 64'(m_sal));
        chk("canal", 64'(bus.Canal), 64'(m_can));
    endtask

    task automatic rst_pulse();
        reset = 1'b1;
        #1;
        m_vld = 1'b0;
        m_sal = '0;
        m_can = 0;
        m_ptr = N - 1;
        chk("rst_aceptado", 64'(bus.Aceptado), 64'd0);
        chk("rst_salida", 64'(bus.Salida), 64'd0);
        chk("rst_valida", 64'(bus.Salida_Valida), 64'd0);
        chk("rst_canal", 64'(bus.Canal), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [N*ANCHO-1:0] d;
        int exp_rr[8];
        reset        = 1'b1;
        bus.Modo     = 1'b1;
        bus.Control  = '0;
        bus.Validos  = 4'b1111;
        bus.Listo    = 1'b1;
        bus.Entradas = '0;
        rst_pulse();

        // Round-robin fairness with all channels requesting.
        exp_rr = '{0, 1, 2, 3, 0, 1, 2, 3};
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 0, 4'b1111, 1'b1, rnd_data());
            chk("rr_all_canal", 64'(bus.Canal), 64'(exp_rr[i]));
        end
        exp_rr = '{1, 3, 1, 3, 0, 0, 0, 0};
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 0, 4'b1010, 1'b1, rnd_data());
            chk("rr_1010_canal", 64'(bus.Canal), 64'(exp_rr[i]));
        end

        // Fixed select, then an invalid selected channel drains the output.
        d = rnd_data();
        d[2*ANCHO +: ANCHO] = 32'hA5A5_0002;
        bus.Modo = 1'b0; bus.Control = 2'd2; bus.Validos = 4'b0100; bus.Listo = 1'b1;
        bus.Entradas = d;
        #1;
        chk("fix_aceptado_lit", 64'(bus.Aceptado), 64'b0100);
        cycle(1'b0, 2, 4'b0100, 1'b1, d);
        chk("fix_salida_lit", 64'(bus.Salida), 64'hA5A5_0002);
        chk("fix_canal_lit", 64'(bus.Canal), 64'd2);
        cycle(1'b0, 1, 4'b0100, 1'b1, rnd_data());
        chk("fix_novalid_lit", 64'(bus.Salida_Valida), 64'd0);

        // Backpressure: hold a word while inputs churn, then release with an immediate reload.
        cycle(1'b0, 2, 4'b0100, 1'b1, d);
        for (int i = 0; i < 5; i++) begin
            cycle(1'($urandom), $urandom_range(0, N-1), 4'($urandom), 1'b0, rnd_data());
            chk("bp_salida_lit", 64'(bus.Salida), 64'hA5A5_0002);
            chk("bp_canal_lit", 64'(bus.Canal), 64'd2);
        end
        cycle(1'b1, 0, 4'b1111, 1'b1, rnd_data());
        chk("bp_release_canal_lit", 64'(bus.Canal), 64'd0);
        chk("bp_release_valid_lit", 64'(bus.Salida_Valida), 64'd1);

        // Pointer wrap and skip.
        cycle(1'b1, 0, 4'b1000, 1'b1, rnd_data());
        chk("wrap_to3_lit", 64'(bus.Canal), 64'd3);
        cycle(1'b1, 0, 4'b0100, 1'b1, rnd_data());
        chk("wrap_skip2_lit", 64'(bus.Canal), 64'd2);
        cycle(1'b1, 0, 4'b0001, 1'b1, rnd_data());
        chk("wrap_to0_lit", 64'(bus.Canal), 64'd0);

        // Mid-flight reset discards the held word and restores channel-0 priority.
        cycle(1'b0, 1, 4'b0010, 1'b1, rnd_data());
        cycle(1'b0, 0, 4'b0000, 1'b0, rnd_data());
        bus.Validos = 4'b1111;
        rst_pulse();
        cycle(1'b1, 0, 4'b1111, 1'b1, rnd_data());
        chk("post_rst_canal_lit", 64'(bus.Canal), 64'd0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) rst_pulse();
            cycle(1'($urandom), $urandom_range(0, N-1), 4'($urandom),
                  $urandom_range(0, 9) < 7, rnd_data());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
